video_pattern_gen: RTL and testbench

AXI4-Stream video source on the pixel clock. Generates full frames of a selectable test pattern: colour bars, horizontal grey ramp, checkerboard, or a solid colour. Sits directly upstream of the HDMI transmitter and drives its 32-bit video input (tuser = start of frame, tlast = end of line). Used for bring-up and as the fallback source when no live video is available.

---
 rtl/video_pkg.sv | 48 ++++
 rtl/video_pattern_pixel.sv | 74 +++++++
 rtl/video_pattern_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_video_pattern_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// video_pkg
//   Types and constants shared by the video pattern generator.
//   - pattern_t : pattern selector encoding (matches pattern_sel_i)
//   - state_t   : generator FSM states
//   - rgb_t     : one pixel, R/G/B components at the widest legal size
//                 (3 x 10 bits fits in 32-bit tdata); narrower builds use
//                 the low PX_WIDTH bits of each field
//   - bar_flags : the 8-entry colour-bar table as {R,G,B} on/off flags
package video_pkg;

   localparam int MAX_PX_WIDTH = 10;

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_RAMP  = 2'd1,
      PAT_CHECK = 2'd2,
      PAT_SOLID = 2'd3
   } pattern_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [MAX_PX_WIDTH-1:0] r;
      logic [MAX_PX_WIDTH-1:0] g;
      logic [MAX_PX_WIDTH-1:0] b;
   } rgb_t;

   // Bar order from the left edge: white, yellow, cyan, green,
   // magenta, red, blue, black.
   function automatic logic [2:0] bar_flags(input logic [2:0] idx);
      logic [2:0] flags;
      case (idx)
         3'd0:    flags = 3'b111;
         3'd1:    flags = 3'b110;
         3'd2:    flags = 3'b011;
         3'd3:    flags = 3'b010;
         3'd4:    flags = 3'b101;
         3'd5:    flags = 3'b100;
         3'd6:    flags = 3'b001;
         default: flags = 3'b000;
      endcase
      return flags;
   endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// video_pattern_pixel
//   Purely combinational pixel colour generator.
//   Ports:
//     pattern  in  2          pattern selector (pattern_t encoding)
//     x        in  X_W        pixel column
//     y        in  Y_W        pixel row
//     bar_idx  in  3          colour-bar index for column x
//     solid    in  3*PX_WIDTH solid colour {R,G,B}
//     rgb      out 3*PX_WIDTH pixel colour {R,G,B}
module video_pattern_pixel
   import video_pkg::*;
#(
   parameter int PX_WIDTH   = 10,
   parameter int CHECK_LOG2 = 5,
   parameter int X_W        = 11,
   parameter int Y_W        = 11
) (
   input  logic [1:0]            pattern,
   input  logic [X_W-1:0]        x,
   input  logic [Y_W-1:0]        y,
   input  logic [2:0]            bar_idx,
   input  logic [3*PX_WIDTH-1:0] solid,
   output logic [3*PX_WIDTH-1:0] rgb
);

   localparam logic [MAX_PX_WIDTH-1:0] C_MAX = MAX_PX_WIDTH'((1 << PX_WIDTH) - 1);

   // Zero-extended coordinates so the checker bit and the ramp slice are
   // always in range, whatever the frame size.
   logic [31:0] x_ext;
   logic [31:0] y_ext;
   logic [2:0]  flags;
   logic        check_black;
   rgb_t        pix;
   logic        unused_bits;

   assign x_ext = 32'(x);
   assign y_ext = 32'(y);

   always_comb begin
      pix         = '0;
      flags       = bar_flags(bar_idx);
      check_black = x_ext[CHECK_LOG2] ^ y_ext[CHECK_LOG2];
      case (pattern_t'(pattern))
         PAT_BARS: begin
            pix.r = flags[2] ? C_MAX : '0;
            pix.g = flags[1] ? C_MAX : '0;
            pix.b = flags[0] ? C_MAX : '0;
         end
         PAT_RAMP: begin
            // Truncation makes the ramp wrap every 2**PX_WIDTH pixels.
            pix.r = MAX_PX_WIDTH'(x_ext[PX_WIDTH-1:0]);
            pix.g = MAX_PX_WIDTH'(x_ext[PX_WIDTH-1:0]);
            pix.b = MAX_PX_WIDTH'(x_ext[PX_WIDTH-1:0]);
         end
         PAT_CHECK: begin
            pix.r = check_black ? '0 : C_MAX;
            pix.g = check_black ? '0 : C_MAX;
            pix.b = check_black ? '0 : C_MAX;
         end
         default: begin
            pix.r = MAX_PX_WIDTH'(solid[3*PX_WIDTH-1 -: PX_WIDTH]);
            pix.g = MAX_PX_WIDTH'(solid[2*PX_WIDTH-1 -: PX_WIDTH]);
            pix.b = MAX_PX_WIDTH'(solid[PX_WIDTH-1:0]);
         end
      endcase
   end

   assign rgb = {pix.r[PX_WIDTH-1:0], pix.g[PX_WIDTH-1:0], pix.b[PX_WIDTH-1:0]};

   // Only some coordinate bits matter for a given configuration.
   assign unused_bits = ^{x_ext, y_ext, pix};

endmodule

// File: rtl/video_pattern_gen.sv
// video_pattern_gen
//   AXI4-Stream test-pattern video source (colour bars, grey ramp,
//   checkerboard, solid colour) feeding a 32-bit video sink.
//   Ports:
//     px_clk_i        in  1          pixel clock
//     rst_i           in  1          asynchronous active-high reset
//     en_i            in  1          generator enable, sampled at frame boundaries
//     pattern_sel_i   in  2          pattern select, latched at frame start
//     solid_color_i   in  3*PX_WIDTH solid colour {R,G,B}, latched at frame start
//     video_o_tdata   out 32         {zero pad, R, G, B}
//     video_o_tvalid  out 1          pixel valid
//     video_o_tready  in  1          downstream ready
//     video_o_tuser   out 1          start of frame (pixel 0,0)
//     video_o_tlast   out 1          end of line
//     frame_cnt_o     out 16         completed frames, wrapping
//     busy_o          out 1          frame in progress
module video_pattern_gen
   import video_pkg::*;
#(
   parameter int PX_WIDTH    = 10,
   parameter int FRAME_RES_X = 1920,
   parameter int FRAME_RES_Y = 1080,
   parameter int CHECK_LOG2  = 5
) (
   input  logic                  px_clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic [1:0]            pattern_sel_i,
   input  logic [3*PX_WIDTH-1:0] solid_color_i,
   output logic [31:0]           video_o_tdata,
   output logic                  video_o_tvalid,
   input  logic                  video_o_tready,
   output logic                  video_o_tuser,
   output logic                  video_o_tlast,
   output logic [15:0]           frame_cnt_o,
   output logic                  busy_o
);

   localparam int X_W  = $clog2(FRAME_RES_X);
   localparam int Y_W  = (FRAME_RES_Y > 1) ? $clog2(FRAME_RES_Y) : 1;
   localparam int BW   = FRAME_RES_X / 8;
   localparam int BC_W = (BW > 1) ? $clog2(BW) : 1;

   localparam logic [X_W-1:0]  X_LAST  = X_W'(FRAME_RES_X - 1);
   localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(FRAME_RES_Y - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(BW - 1);
   localparam logic [X_W-1:0]  X_ONE   = X_W'(1);
   localparam logic [Y_W-1:0]  Y_ONE   = Y_W'(1);
   localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

   generate
      if ((FRAME_RES_X % 8) != 0 || FRAME_RES_X < 8 || FRAME_RES_Y < 1 || 3*PX_WIDTH > 32) begin : g_bad_params
         $error("video_pattern_gen: illegal parameter combination");
      end
   endgenerate

   state_t                state_reg, state_next;
   logic [X_W-1:0]        x_reg, x_next;
   logic [Y_W-1:0]        y_reg, y_next;
   logic [BC_W-1:0]       bar_cnt_reg, bar_cnt_next;
   logic [2:0]            bar_idx_reg, bar_idx_next;
   logic [1:0]            pattern_reg, pattern_next;
   logic [3*PX_WIDTH-1:0] solid_reg, solid_next;
   logic [31:0]           tdata_reg, tdata_next;
   logic                  tuser_reg, tuser_next;
   logic                  tlast_reg, tlast_next;
   logic                  tvalid_reg, tvalid_next;
   logic                  busy_reg, busy_next;
   logic [15:0]           frame_cnt_reg, frame_cnt_next;

   logic                  handshake;
   logic                  end_of_frame;
   logic                  start;   // load pixel (0,0) of a new frame
   logic                  load;    // output register takes a new pixel
   logic                  stop;    // frame finished with en_i low

   logic [1:0]            pix_pattern;
   logic [3*PX_WIDTH-1:0] pix_solid;
   logic [3*PX_WIDTH-1:0] pix_rgb;

   assign handshake    = tvalid_reg & video_o_tready;
   assign end_of_frame = (x_reg == X_LAST) && (y_reg == Y_LAST);

   // FSM, coordinate and bar counters.
   always_comb begin
      state_next     = state_reg;
      x_next         = x_reg;
      y_next         = y_reg;
      bar_cnt_next   = bar_cnt_reg;
      bar_idx_next   = bar_idx_reg;
      pattern_next   = pattern_reg;
      solid_next     = solid_reg;
      frame_cnt_next = frame_cnt_reg;
      start          = 1'b0;
      load           = 1'b0;
      stop           = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (en_i) begin
               start      = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (handshake) begin
               if (end_of_frame) begin
                  frame_cnt_next = frame_cnt_reg + 16'd1;
                  if (en_i) begin
                     start = 1'b1;
                  end else begin
                     stop       = 1'b1;
                     state_next = ST_IDLE;
                  end
               end else begin
                  load = 1'b1;
                  if (x_reg == X_LAST) begin
                     x_next       = '0;
                     y_next       = y_reg + Y_ONE;
                     bar_cnt_next = '0;
                     bar_idx_next = '0;
                  end else begin
                     x_next = x_reg + X_ONE;
                     // Bar index advances every BW pixels without a divider.
                     if (bar_cnt_reg == BC_LAST) begin
                        bar_cnt_next = '0;
                        bar_idx_next = bar_idx_reg + 3'd1;
                     end else begin
                        bar_cnt_next = bar_cnt_reg + BC_ONE;
                     end
                  end
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (start) begin
         load         = 1'b1;
         x_next       = '0;
         y_next       = '0;
         bar_cnt_next = '0;
         bar_idx_next = '0;
         pattern_next = pattern_sel_i;
         solid_next   = solid_color_i;
      end
   end

   // The first pixel of a frame must use the freshly sampled selections.
   assign pix_pattern = start ? pattern_sel_i : pattern_reg;
   assign pix_solid   = start ? solid_color_i : solid_reg;

   video_pattern_pixel #(
      .PX_WIDTH   (PX_WIDTH),
      .CHECK_LOG2 (CHECK_LOG2),
      .X_W        (X_W),
      .Y_W        (Y_W)
   ) u_pixel (
      .pattern (pix_pattern),
      .x       (x_next),
      .y       (y_next),
      .bar_idx (bar_idx_next),
      .solid   (pix_solid),
      .rgb     (pix_rgb)
   );

   // AXI output register: only changes on load or at frame end, so the
   // payload is held while the sink stalls.
   always_comb begin
      tdata_next  = tdata_reg;
      tuser_next  = tuser_reg;
      tlast_next  = tlast_reg;
      tvalid_next = tvalid_reg;
      busy_next   = busy_reg;
      if (load) begin
         tdata_next  = 32'(pix_rgb);
         tuser_next  = start;
         tlast_next  = (x_next == X_LAST);
         tvalid_next = 1'b1;
         busy_next   = 1'b1;
      end else if (stop) begin
         tuser_next  = 1'b0;
         tlast_next  = 1'b0;
         tvalid_next = 1'b0;
         busy_next   = 1'b0;
      end
   end

   always_ff @(posedge px_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= ST_IDLE;
         x_reg         <= '0;
         y_reg         <= '0;
         bar_cnt_reg   <= '0;
         bar_idx_reg   <= '0;
         pattern_reg   <= '0;
         solid_reg     <= '0;
         tdata_reg     <= '0;
         tuser_reg     <= 1'b0;
         tlast_reg     <= 1'b0;
         tvalid_reg    <= 1'b0;
         busy_reg      <= 1'b0;
         frame_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         x_reg         <= x_next;
         y_reg         <= y_next;
         bar_cnt_reg   <= bar_cnt_next;
         bar_idx_reg   <= bar_idx_next;
         pattern_reg   <= pattern_next;
         solid_reg     <= solid_next;
         tdata_reg     <= tdata_next;
         tuser_reg     <= tuser_next;
         tlast_reg     <= tlast_next;
         tvalid_reg    <= tvalid_next;
         busy_reg      <= busy_next;
         frame_cnt_reg <= frame_cnt_next;
      end
   end

   assign video_o_tdata  = tdata_reg;
   assign video_o_tvalid = tvalid_reg;
   assign video_o_tuser  = tuser_reg;
   assign video_o_tlast  = tlast_reg;
   assign frame_cnt_o    = frame_cnt_reg;
   assign busy_o         = busy_reg;

endmodule

// File: tb/tb_video_pattern_gen.sv
// tb_video_pattern_gen
//   Randomized bench for video_pattern_gen (10-bit, 16x4 frame, 2-pixel
//   checker squares). A frame-level reference model predicts every beat.
module tb_video_pattern_gen;

   localparam int PXW = 10;
   localparam int RX  = 16;
   localparam int RY  = 4;
   localparam int CL  = 1;

   logic           clk = 1'b0;
   logic           rst_i;
   logic           en_i;
   logic [1:0]     pattern_sel_i;
   logic [3*PXW-1:0] solid_color_i;
   logic [31:0]    video_o_tdata;
   logic           video_o_tvalid;
   logic           video_o_tready;
   logic           video_o_tuser;
   logic           video_o_tlast;
   logic [15:0]    frame_cnt_o;
   logic           busy_o;

   always #5 clk = ~clk;

   video_pattern_gen #(
      .PX_WIDTH    (PXW),
      .FRAME_RES_X (RX),
      .FRAME_RES_Y (RY),
      .CHECK_LOG2  (CL)
   ) dut (
      .px_clk_i       (clk),
      .rst_i          (rst_i),
      .en_i           (en_i),
      .pattern_sel_i  (pattern_sel_i),
      .solid_color_i  (solid_color_i),
      .video_o_tdata  (video_o_tdata),
      .video_o_tvalid (video_o_tvalid),
      .video_o_tready (video_o_tready),
      .video_o_tuser  (video_o_tuser),
      .video_o_tlast  (video_o_tlast),
      .frame_cnt_o    (frame_cnt_o),
      .busy_o         (busy_o)
   );

   int checks = 0;
   int errors = 0;

   // stimulus knobs
   logic           drv_en      = 1'b0;
   int             drv_pat     = 0;
   logic [3*PXW-1:0] drv_solid = '0;
   int             ready_pct   = 100;
   logic           rand_pat    = 1'b0;
   logic           rand_solid  = 1'b0;

   // reference model state
   logic           m_active = 1'b0;
   int             m_x = 0, m_y = 0, m_pat = 0, m_frames = 0, m_beat = 0;
   logic [3*PXW-1:0] m_solid = '0;
   logic           held_valid = 1'b0;
   logic [31:0]    held_data  = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Expected pixel straight from the pattern definitions.
   function automatic logic [31:0] ref_pixel(input int pat, input int x, input int y,
                                             input logic [3*PXW-1:0] solid);
      int bar_r [8];
      int bar_g [8];
      int bar_b [8];
      int m, r, g, b, idx;
      // white, yellow, cyan, green, magenta, red, blue, black
      bar_r = '{1, 1, 0, 0, 1, 1, 0, 0};
      bar_g = '{1, 1, 1, 1, 0, 0, 0, 0};
      bar_b = '{1, 0, 1, 0, 1, 0, 1, 0};
      m = (1 << PXW) - 1;
      r = 0; g = 0; b = 0;
      case (pat)
         0: begin
            idx = x / (RX / 8);
            r = bar_r[idx] * m; g = bar_g[idx] * m; b = bar_b[idx] * m;
         end
         1: begin
            r = x % (1 << PXW); g = r; b = r;
         end
         2: begin
            r = ((((x >> CL) ^ (y >> CL)) & 1) == 0) ? m : 0; g = r; b = r;
         end
         default: return 32'(solid);
      endcase
      return 32'((r << (2*PXW)) | (g << PXW) | b);
   endfunction

   // One clock: drive inputs on the falling edge, check the DUT against
   // the model, then predict what the next rising edge does.
   task automatic step();
      logic [31:0] exp;
      @(negedge clk);
      rst_i          = 1'b0;
      en_i           = drv_en;
      video_o_tready = ($urandom_range(99) < ready_pct);
      pattern_sel_i  = rand_pat   ? 2'($urandom_range(3)) : 2'(drv_pat);
      solid_color_i  = rand_solid ? 30'($urandom)         : drv_solid;

      check_val("tvalid", 32'(video_o_tvalid), 32'(m_active));
      check_val("busy", 32'(busy_o), 32'(m_active));
      check_val("frame_cnt", 32'(frame_cnt_o), 32'(16'(m_frames)));
      if (m_active) begin
         exp = ref_pixel(m_pat, m_x, m_y, m_solid);
         check_val("tdata", video_o_tdata, exp);
         check_val("tuser", 32'(video_o_tuser), 32'((m_x == 0) && (m_y == 0)));
         check_val("tlast", 32'(video_o_tlast), 32'(m_x == RX - 1));
      end
      if (held_valid)
         check_val("hold_tdata", video_o_tdata, held_data);
      held_valid = video_o_tvalid && !video_o_tready;
      held_data  = video_o_tdata;

      if (m_active && video_o_tready) begin
         $display("beat frame=%0d x=%0d y=%0d pat=%0d tdata=0x%08h user=%0b last=%0b",
                  m_frames, m_x, m_y, m_pat, video_o_tdata, video_o_tuser, video_o_tlast);
         m_beat++;
         if (m_x == RX - 1 && m_y == RY - 1) begin
            check_val("beats_per_frame", 32'(m_beat), 32'(RX * RY));
            m_frames++;
            if (en_i) begin
               m_pat = int'(pattern_sel_i); m_solid = solid_color_i;
               m_x = 0; m_y = 0; m_beat = 0;
            end else begin
               m_active = 1'b0;
            end
         end else if (m_x == RX - 1) begin
            m_x = 0; m_y++;
         end else begin
            m_x++;
         end
      end else if (!m_active && en_i) begin
         m_active = 1'b1;
         m_pat = int'(pattern_sel_i); m_solid = solid_color_i;
         m_x = 0; m_y = 0; m_beat = 0;
      end
   endtask

   task automatic run_frames(input int n);
      int target;
      int budget;
      target = m_frames + n;
      budget = n * RX * RY * 20 + 50;
      while (m_frames < target && budget > 0) begin
         step();
         budget--;
      end
      if (m_frames < target)
         check_val("frame_timeout", 32'(m_frames), 32'(target));
   endtask

   task automatic run_to_beat(input int beat);
      int budget;
      budget = 2000;
      while (m_beat != beat && budget > 0) begin
         step();
         budget--;
      end
      if (m_beat != beat)
         check_val("beat_timeout", 32'(m_beat), 32'(beat));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not end, got running expected finished");
      $fatal(1);
   end

   initial begin
      int budget;
      rst_i          = 1'b1;
      en_i           = 1'b0;
      video_o_tready = 1'b0;
      pattern_sel_i  = '0;
      solid_color_i  = '0;
      repeat (3) @(negedge clk);
      check_val("rst_tvalid", 32'(video_o_tvalid), 32'd0);
      check_val("rst_tdata", video_o_tdata, 32'd0);
      check_val("rst_tuser", 32'(video_o_tuser), 32'd0);
      check_val("rst_tlast", 32'(video_o_tlast), 32'd0);
      check_val("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
      check_val("rst_busy", 32'(busy_o), 32'd0);

      // colour bars, sink always ready
      drv_pat = 0; ready_pct = 100; drv_en = 1'b1;
      run_frames(2);

      // grey ramp with back-pressure
      drv_pat = 1; ready_pct = 60;
      run_frames(3);

      // checkerboard
      drv_pat = 2; ready_pct = 70;
      run_frames(2);

      // solid colour, then solid changing every cycle
      drv_pat = 3; drv_solid = {10'h155, 10'h0AA, 10'h3FF}; ready_pct = 80;
      run_frames(2);
      rand_solid = 1'b1;
      run_frames(2);

      // everything random
      rand_pat = 1'b1; ready_pct = 50;
      run_frames(4);
      rand_pat = 1'b0; rand_solid = 1'b0;

      // enable dropped mid-frame: frame completes, then idle
      drv_pat = 0; ready_pct = 75;
      run_to_beat(10);
      drv_en = 1'b0;
      budget = 1000;
      while (m_active && budget > 0) begin
         step();
         budget--;
      end
      check_val("idle_after_drop", 32'(m_active), 32'd0);
      repeat (5) step();
      drv_en = 1'b1; drv_pat = 1;
      run_frames(1);

      // asynchronous reset mid-frame
      drv_pat = 2; ready_pct = 90;
      run_to_beat(30);
      #1 rst_i = 1'b1;
      #1;
      check_val("arst_tvalid", 32'(video_o_tvalid), 32'd0);
      check_val("arst_busy", 32'(busy_o), 32'd0);
      check_val("arst_frame_cnt", 32'(frame_cnt_o), 32'd0);
      m_active = 1'b0; m_frames = 0; m_beat = 0; held_valid = 1'b0;
      @(posedge clk);
      run_frames(2);

      drv_en = 1'b0;
      repeat (3 * RX * RY) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
